gemm_tile_sequencer: RTL and testbench

GEMM_TILE_SEQUENCER -- requirements
Module: gemm_tile_sequencer

---
 rtl/gemm_tile_sequencer_pkg.sv | 32 +++
 rtl/gemm_tile_sequencer_acc_drain_ctrl.sv | 25 ++
 rtl/gemm_tile_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_gemm_tile_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_tile_sequencer_pkg.sv
// Shared types and limits for the GEMM tile sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: state encoding seq_state_t, default k_len width, core array
// dimensions and the legal n_cols range with a helper to test it.
package Config;

    localparam int SEQ_KLEN_W = 8;

    // Core array geometry; mux configuration buses are one bit narrower.
    localparam int CORE_ROWS = 16;
    localparam int CORE_COLS = 16;

    // Legal range for the number of active output columns.
    localparam int NCOLS_MIN = 1;
    localparam int NCOLS_MAX = 16;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t IDLE     = 3'd0;
    localparam seq_state_t WLOAD    = 3'd1;
    localparam seq_state_t FEED     = 3'd2;
    localparam seq_state_t WAIT_ACC = 3'd3;
    localparam seq_state_t DRAIN    = 3'd4;
    localparam seq_state_t DONE     = 3'd5;

    function automatic logic ncols_legal(input logic [4:0] n);
        return (n >= 5'(NCOLS_MIN)) && (n <= 5'(NCOLS_MAX));
    endfunction

endpackage

// File: rtl/gemm_tile_sequencer_acc_drain_ctrl.sv
// Accumulator drain control: per-group read enables and all-empty detect.
// Latency: purely combinational, 0 cycles.
// Backpressure: read enables are held low while i_out_ready is low.
//
// Ports:
//   i_active       - sequencer is in its drain phase
//   i_out_ready    - downstream accepts readout this cycle
//   i_acc_empty    - per-accumulator empty flags
//   i_group_active - column groups in use for this tile ({gt12, gt8, gt4, 1})
//   o_rd_en        - accumulator read enables
//   o_all_empty    - every active group is empty (inactive groups ignored)
module acc_drain_ctrl (
    input  logic       i_active,
    input  logic       i_out_ready,
    input  logic [3:0] i_acc_empty,
    input  logic [3:0] i_group_active,
    output logic [3:0] o_rd_en,
    output logic       o_all_empty
);

    assign o_rd_en     = {4{i_active & i_out_ready}} & ~i_acc_empty & i_group_active;
    // An inactive group never holds data, so it counts as empty.
    assign o_all_empty = &(i_acc_empty | ~i_group_active);

endmodule

// File: rtl/gemm_tile_sequencer.sv
// GEMM tile sequencer: weight load, input feed, accumulate wait and drain.
// Latency: strobes are combinational from src_vld (0 cycles); one state step per accepted row.
// Backpressure: src_vld gaps stall row counting; out_ready low stalls drain reads.
//
// Ports: clk/rst (async active-high); start + tile config (k_len, n_cols,
// accumulate, if_mux_cfg, w_mux_cfg); source handshake src_vld/src_rdy;
// datapath strobes wfetch/if_en/store/overwrite, mux selects, column-group
// enables gt4/gt8/gt12, accumulator drain acc_is_done/acc_empty/out_ready/
// accums_rd_en; status busy/done/err.
// Build option: define GEMM_SEQ_TIMEOUT_EN to add a WAIT_ACC watchdog of
// SEQ_TIMEOUT cycles that ends the tile with err.
module gemm_tile_sequencer
    import Config::*;
#(
    parameter int SEQ_TIMEOUT = 1024,
    parameter int KLEN_W      = SEQ_KLEN_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [KLEN_W-1:0]    k_len,
    input  logic [4:0]           n_cols,
    input  logic                 accumulate,
    input  logic [CORE_ROWS-2:0] if_mux_cfg,
    input  logic [CORE_COLS-2:0] w_mux_cfg,
    input  logic                 src_vld,
    input  logic                 acc_is_done,
    input  logic [3:0]           acc_empty,
    input  logic                 out_ready,
    output logic                 wfetch,
    output logic                 if_en,
    output logic                 store,
    output logic                 overwrite,
    output logic [CORE_ROWS-2:0] if_mux_sel,
    output logic [CORE_COLS-2:0] w_mux_sel,
    output logic                 gt4,
    output logic                 gt8,
    output logic                 gt12,
    output logic [3:0]           accums_rd_en,
    output logic                 src_rdy,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    seq_state_t           r_state;
    seq_state_t           w_state_nxt;
    logic                 w_err_nxt;

    logic [KLEN_W-1:0]    r_klen;
    logic [4:0]           r_ncols;
    logic                 r_accum;
    logic [CORE_ROWS-2:0] r_if_mux;
    logic [CORE_COLS-2:0] r_w_mux;
    logic [3:0]           r_row_cnt;
    logic [KLEN_W-1:0]    r_k_cnt;
    logic                 r_err;

    logic                 w_wfetch;
    logic                 w_if_en;
    logic                 w_row_last;
    logic                 w_k_last;
    logic                 w_first_if;
    logic                 w_latch;
    logic                 w_all_empty;
    logic                 w_wd_expired;
    logic [3:0]           w_group_active;

    assign w_wfetch   = (r_state == WLOAD) & src_vld;
    assign w_if_en    = (r_state == FEED) & src_vld;
    assign w_row_last = w_wfetch & (r_row_cnt == 4'd15);
    // FEED is only entered with r_klen != 0, so klen-1 never underflows here.
    assign w_k_last   = w_if_en & (r_k_cnt == (r_klen - KLEN_W'(1)));
    assign w_first_if = w_if_en & (r_k_cnt == '0);
    assign w_latch    = (r_state == IDLE) & start & ncols_legal(n_cols);

    assign gt4  = r_ncols > 5'd4;
    assign gt8  = r_ncols > 5'd8;
    assign gt12 = r_ncols > 5'd12;
    assign w_group_active = {gt12, gt8, gt4, 1'b1};

    acc_drain_ctrl u_drain (
        .i_active       (r_state == DRAIN),
        .i_out_ready    (out_ready),
        .i_acc_empty    (acc_empty),
        .i_group_active (w_group_active),
        .o_rd_en        (accums_rd_en),
        .o_all_empty    (w_all_empty)
    );

`ifdef GEMM_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(SEQ_TIMEOUT + 1);
    logic [WD_W-1:0] r_wd;

    // Counts cycles spent in WAIT_ACC; the entry cycle is count 0, so the
    // state lasts exactly SEQ_TIMEOUT cycles before the watchdog fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd <= '0;
        end else if (r_state == WAIT_ACC) begin
            r_wd <= r_wd + 1'b1;
        end else begin
            r_wd <= '0;
        end
    end

    assign w_wd_expired = (r_state == WAIT_ACC) && (r_wd == WD_W'(SEQ_TIMEOUT - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (SEQ_TIMEOUT == 0);
    assign w_wd_expired     = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (ncols_legal(n_cols)) begin
                        w_state_nxt = WLOAD;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            WLOAD: begin
                if (w_row_last) begin
                    if (r_klen == '0) begin
                        w_state_nxt = DONE;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = FEED;
                    end
                end
            end
            FEED: begin
                if (w_k_last) begin
                    w_state_nxt = WAIT_ACC;
                end
            end
            WAIT_ACC: begin
                // A completion arriving with the watchdog expiry wins.
                if (acc_is_done) begin
                    w_state_nxt = DRAIN;
                end else if (w_wd_expired) begin
                    w_state_nxt = DONE;
                    w_err_nxt   = 1'b1;
                end
            end
            DRAIN: begin
                if (w_all_empty) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_klen    <= '0;
            r_ncols   <= '0;
            r_accum   <= 1'b0;
            r_if_mux  <= '0;
            r_w_mux   <= '0;
            r_row_cnt <= '0;
            r_k_cnt   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
            if (w_latch) begin
                r_klen    <= k_len;
                r_ncols   <= n_cols;
                r_accum   <= accumulate;
                r_if_mux  <= if_mux_cfg;
                r_w_mux   <= w_mux_cfg;
                r_row_cnt <= '0;
                r_k_cnt   <= '0;
            end else begin
                if (w_wfetch) begin
                    r_row_cnt <= r_row_cnt + 4'd1;
                end
                if (w_if_en) begin
                    r_k_cnt <= r_k_cnt + KLEN_W'(1);
                end
            end
        end
    end

    assign wfetch     = w_wfetch;
    assign if_en      = w_if_en;
    assign store      = w_first_if & r_accum;
    assign overwrite  = w_first_if & ~r_accum;
    assign src_rdy    = (r_state == WLOAD) | (r_state == FEED);
    assign busy       = r_state != IDLE;
    assign done       = r_state == DONE;
    assign err        = r_err;
    // Selects are only meaningful while a tile is in flight.
    assign if_mux_sel = busy ? r_if_mux : '0;
    assign w_mux_sel  = busy ? r_w_mux : '0;

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Self-checking bench for gemm_tile_sequencer.
// Latency: n/a.
// Backpressure: exercised via src_vld gaps and out_ready stalls.
module tb_gemm_tile_sequencer;
    import Config::*;

`ifdef GEMM_SEQ_TIMEOUT_EN
    localparam int TB_TIMEOUT = 20;
`else
    localparam int TB_TIMEOUT = 1024;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [7:0]           k_len;
    logic [4:0]           n_cols;
    logic                 accumulate;
    logic [CORE_ROWS-2:0] if_mux_cfg;
    logic [CORE_COLS-2:0] w_mux_cfg;
    logic                 src_vld;
    logic                 acc_is_done;
    logic [3:0]           acc_empty;
    logic                 out_ready;
    logic                 wfetch, if_en, store, overwrite;
    logic [CORE_ROWS-2:0] if_mux_sel;
    logic [CORE_COLS-2:0] w_mux_sel;
    logic                 gt4, gt8, gt12;
    logic [3:0]           accums_rd_en;
    logic                 src_rdy, busy, done, err;

    always #5 clk = ~clk;

    gemm_tile_sequencer #(
        .SEQ_TIMEOUT (TB_TIMEOUT),
        .KLEN_W      (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .k_len        (k_len),
        .n_cols       (n_cols),
        .accumulate   (accumulate),
        .if_mux_cfg   (if_mux_cfg),
        .w_mux_cfg    (w_mux_cfg),
        .src_vld      (src_vld),
        .acc_is_done  (acc_is_done),
        .acc_empty    (acc_empty),
        .out_ready    (out_ready),
        .wfetch       (wfetch),
        .if_en        (if_en),
        .store        (store),
        .overwrite    (overwrite),
        .if_mux_sel   (if_mux_sel),
        .w_mux_sel    (w_mux_sel),
        .gt4          (gt4),
        .gt8          (gt8),
        .gt12         (gt12),
        .accums_rd_en (accums_rd_en),
        .src_rdy      (src_rdy),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {19'd0, wfetch, if_en, store, overwrite, if_mux_sel, w_mux_sel,
                gt4, gt8, gt12, accums_rd_en, src_rdy, busy, done, err};
    endfunction

    typedef struct {
        int wf, ie, st, ow, rdy, rdsum, rdor, gt, err, ifm, wm, chk_wait, wait_c;
    } exp_t;

    exp_t exp_q[$];

    // Per-tile tallies gathered by the monitor.
    int t_wf, t_ie, t_st, t_ow, t_rdy, t_rdsum, t_rdor, t_bad_rd, t_bad_strobe, t_wait;

    task automatic clear_tally();
        t_wf = 0; t_ie = 0; t_st = 0; t_ow = 0; t_rdy = 0; t_rdsum = 0;
        t_rdor = 0; t_bad_rd = 0; t_bad_strobe = 0; t_wait = 0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            clear_tally();
        end else begin
            t_wf  += int'(wfetch);
            t_st  += int'(store);
            t_ow  += int'(overwrite);
            t_rdy += int'(src_rdy);
            if ((store | overwrite) && !(if_en && t_ie == 0)) t_bad_strobe++;
            t_ie  += int'(if_en);
            t_rdsum += $countones(accums_rd_en);
            t_rdor  |= int'(accums_rd_en);
            if (accums_rd_en != 4'd0 && !out_ready) t_bad_rd++;
            if (busy && !src_rdy && !done) t_wait++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("wfetch_cnt", t_wf, e.wf);
                    check_eq("if_en_cnt", t_ie, e.ie);
                    check_eq("store_cnt", t_st, e.st);
                    check_eq("overwrite_cnt", t_ow, e.ow);
                    check_eq("strobe_pos", t_bad_strobe, 0);
                    check_eq("rdy_cycles", t_rdy, e.rdy);
                    check_eq("rd_en_sum", t_rdsum, e.rdsum);
                    check_eq("rd_en_or", t_rdor, e.rdor);
                    check_eq("rd_wo_ready", t_bad_rd, 0);
                    check_eq("gt_bits", {gt12, gt8, gt4}, e.gt);
                    check_eq("err_at_done", err, e.err);
                    check_eq("if_mux_sel", if_mux_sel, e.ifm);
                    check_eq("w_mux_sel", w_mux_sel, e.wm);
                    if (e.chk_wait != 0) check_eq("wait_acc_cycles", t_wait, e.wait_c);
                end
                clear_tally();
            end
        end
    end

    task automatic do_start(input int k, input int n, input bit acc, input int ifm, input int wm);
        @(posedge clk); #1;
        start = 1'b1; k_len = 8'(k); n_cols = 5'(n); accumulate = acc;
        if_mux_cfg = 15'(ifm); w_mux_cfg = 15'(wm);
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble config inputs to prove the latched copy is what drives out.
        if_mux_cfg = ~if_mux_cfg; w_mux_cfg = ~w_mux_cfg; n_cols = 5'd0; accumulate = ~acc;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq(tag, busy, 0);
    endtask

    task automatic run_tile(input int k, input int n, input bit acc, input bit toggle,
                            input int hold, input bit send_acc);
        exp_t e;
        int   g;
        int   cyc = 0;
        int   ifm = int'($urandom_range(0, 32767));
        int   wm  = int'($urandom_range(0, 32767));
        g          = 1 + int'(n > 4) + int'(n > 8) + int'(n > 12);
        e.wf       = 16;
        e.ie       = k;
        e.st       = int'(k > 0 && acc);
        e.ow       = int'(k > 0 && !acc);
        e.rdy      = toggle ? 2 * (16 + k) : 16 + k;
        e.gt       = int'({n > 12, n > 8, n > 4});
        e.rdsum    = (k > 0 && send_acc) ? g * (g + 1) / 2 : 0;
        e.rdor     = (k > 0 && send_acc) ? (1 << g) - 1 : 0;
        e.err      = int'(k == 0 || !send_acc);
        e.ifm      = ifm;
        e.wm       = wm;
        e.chk_wait = int'(k > 0 && !send_acc);
        e.wait_c   = TB_TIMEOUT;
        exp_q.push_back(e);

        do_start(k, n, acc, ifm, wm);
        while (src_rdy && cyc < 1000) begin
            src_vld = toggle ? cyc[0] : 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        src_vld = 1'b0;

        if (k > 0 && send_acc) begin
            acc_is_done = 1'b1;
            out_ready   = (hold == 0);
            @(posedge clk); #1;
            acc_is_done = 1'b0;
            repeat (hold) begin
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                acc_empty[i] = 1'b1;
            end
        end
        wait_idle("tile_end");
        acc_empty = 4'd0;
        out_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; k_len = '0; n_cols = '0; accumulate = 1'b0;
        if_mux_cfg = '0; w_mux_cfg = '0; src_vld = 1'b0; acc_is_done = 1'b0;
        acc_empty = 4'd0; out_ready = 1'b1;
        clear_tally();
        #2;
        check_eq("reset_outs", all_outs(), 64'd0);
        src_vld = 1'b1;
        #1;
        check_eq("reset_outs_vld", all_outs(), 64'd0);
        src_vld = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Full tile, continuous source, overwrite.
        run_tile(8, 16, 1'b0, 1'b0, 0, 1'b1);
        // Same tile with 0101 source gaps: same row counts, double the cycles.
        run_tile(8, 16, 1'b0, 1'b1, 0, 1'b1);
        // Two active groups, accumulate mode.
        run_tile(3, 5, 1'b1, 1'b0, 0, 1'b1);
        // Downstream stall of 10 drain cycles.
        run_tile(4, 12, 1'b0, 1'b0, 10, 1'b1);
        // Zero-length feed.
        run_tile(0, 8, 1'b1, 1'b0, 0, 1'b1);

        // Illegal n_cols requests are rejected with a single err pulse.
        for (int r = 0; r < 2; r++) begin
            @(posedge clk); #1;
            start = 1'b1; k_len = 8'd4; n_cols = (r == 0) ? 5'd0 : 5'd17;
            @(posedge clk); #1;
            start = 1'b0;
            check_eq("reject_err", err, 1);
            check_eq("reject_busy", busy, 0);
            @(posedge clk); #1;
            check_eq("reject_err_clr", err, 0);
            check_eq("reject_idle", busy, 0);
        end

        // Reset in the middle of FEED aborts the tile immediately.
        do_start(8, 16, 1'b0, 15'h1234, 15'h0abc);
        src_vld = 1'b1;
        repeat (19) @(posedge clk);
        #1;
        check_eq("pre_rst_if_en", if_en, 1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_outs", all_outs(), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_outs", all_outs(), 64'd0);
        src_vld = 1'b0;
        run_tile(8, 16, 1'b0, 1'b0, 0, 1'b1);

`ifdef GEMM_SEQ_TIMEOUT_EN
        // No completion from the datapath: watchdog ends the tile with err.
        run_tile(2, 4, 1'b1, 1'b0, 0, 1'b0);
`endif

        repeat (3) @(posedge clk);
        check_eq("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
